// File: rtl/kyber_pkg.sv
// Shared Kyber definitions: exchange FSM states and per-rank pk/ciphertext word counts.
package kyber_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_PK_XFER,
        S_CT_XFER,
        S_DONE,
        S_ERR
    } xchg_state_e;

    function automatic logic k_legal(input logic [2:0] k);
        return (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
    endfunction

    // Public key is 96k+8 words.
    function automatic logic [CNT_W-1:0] pk_words(input logic [2:0] k);
        case (k)
            3'd2:    return 10'd200;
            3'd3:    return 10'd296;
            3'd4:    return 10'd392;
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] ct_words(input logic [2:0] k);
        case (k)
            3'd2:    return 10'd192;
            3'd3:    return 10'd272;
            3'd4:    return 10'd392;
            default: return 10'd0;
        endcase
    endfunction

endpackage

// File: rtl/kyber_word_fwd.sv
// One registered forwarding stage (valid + data); data only loads on a valid word.
module kyber_word_fwd #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/kyber_xchg_ctrl.sv
// Key-exchange sequencer: starts both cores, relays pk server->client, then ciphertext client->server.
module kyber_xchg_ctrl
    import kyber_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        k,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              srv_start,
    output logic              cli_start,
    input  logic              srv_valid,
    input  logic [WORD_W-1:0] srv_dout,
    input  logic              cli_valid,
    input  logic [WORD_W-1:0] cli_dout,
    output logic              cli_wen,
    output logic [WORD_W-1:0] cli_din,
    output logic              srv_wen,
    output logic [WORD_W-1:0] srv_din,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    xchg_state_e      state, nxt;
    logic [2:0]       k_q;
    logic [TMO_W-1:0] tmo_cnt;

    logic start_ok, pk_fire, ct_fire, pk_last, ct_last, in_phase, tmo_hit;

    // Only the source that owns the current phase is ever forwarded.
    assign start_ok = (state == S_IDLE) && start && k_legal(k);
    assign pk_fire  = (state == S_PK_XFER) && srv_valid;
    assign ct_fire  = (state == S_CT_XFER) && cli_valid;
    assign pk_last  = pk_fire && (word_cnt == pk_words(k_q) - 10'd1);
    assign ct_last  = ct_fire && (word_cnt == ct_words(k_q) - 10'd1);
    assign in_phase = (state == S_PK_XFER) || (state == S_CT_XFER);
    assign tmo_hit  = in_phase && !pk_fire && !ct_fire
                      && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (start) nxt = k_legal(k) ? S_START : S_ERR;
            S_START:   nxt = S_PK_XFER;
            S_PK_XFER: if (pk_last) nxt = S_CT_XFER;
                       else if (tmo_hit) nxt = S_ERR;
            S_CT_XFER: if (ct_last) nxt = S_DONE;
                       else if (tmo_hit) nxt = S_ERR;
            S_DONE:    nxt = S_IDLE;
            S_ERR:     nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k_q       <= '0;
            word_cnt  <= '0;
            tmo_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            srv_start <= 1'b0;
            cli_start <= 1'b0;
        end else begin
            state     <= nxt;
            busy      <= (nxt != S_IDLE);
            done      <= (nxt == S_DONE);
            srv_start <= (nxt == S_START);
            cli_start <= (nxt == S_START);

            // err becomes visible once the ERR cycle is over and sticks until a good start.
            if (start_ok) begin
                k_q <= k;
                err <= 1'b0;
            end else if (state == S_ERR) begin
                err <= 1'b1;
            end

            if (start_ok || pk_last || ct_last)
                word_cnt <= '0;
            else if (pk_fire || ct_fire)
                word_cnt <= word_cnt + 10'd1;

            if ((nxt != state) || pk_fire || ct_fire)
                tmo_cnt <= '0;
            else if (in_phase)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    kyber_word_fwd #(.W(WORD_W)) u_pk_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pk_fire),
        .in_data   (srv_dout),
        .out_valid (cli_wen),
        .out_data  (cli_din)
    );

    kyber_word_fwd #(.W(WORD_W)) u_ct_fwd (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (ct_fire),
        .in_data   (cli_dout),
        .out_valid (srv_wen),
        .out_data  (srv_din)
    );

endmodule

// File: tb/tb_kyber_xchg_ctrl.sv
// Scoreboard bench for kyber_xchg_ctrl: expected words queued at drive time, matched against captured output.
module tb_kyber_xchg_ctrl;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  k;
    logic        busy, done, err, srv_start, cli_start;
    logic        srv_valid, cli_valid;
    logic [31:0] srv_dout, cli_dout;
    logic        cli_wen, srv_wen;
    logic [31:0] cli_din, srv_din;
    logic [9:0]  word_cnt;

    kyber_xchg_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .k(k),
        .busy(busy), .done(done), .err(err),
        .srv_start(srv_start), .cli_start(cli_start),
        .srv_valid(srv_valid), .srv_dout(srv_dout),
        .cli_valid(cli_valid), .cli_dout(cli_dout),
        .cli_wen(cli_wen), .cli_din(cli_din),
        .srv_wen(srv_wen), .srv_din(srv_din),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_cli_q[$], exp_srv_q[$];
    logic [31:0] obs_cli_q[$], obs_srv_q[$];
    int cli_wen_n = 0, srv_wen_n = 0, done_n = 0, sstart_n = 0, cstart_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cli_wen) begin obs_cli_q.push_back(cli_din); cli_wen_n++; end
            if (srv_wen) begin obs_srv_q.push_back(srv_din); srv_wen_n++; end
            if (done)      done_n++;
            if (srv_start) sstart_n++;
            if (cli_start) cstart_n++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int pk_len(input int kk);
        return 96 * kk + 8;
    endfunction

    function automatic int ct_len(input int kk);
        case (kk)
            2: return 192;
            3: return 272;
            default: return 392;
        endcase
    endfunction

    task automatic drain(input string tag);
        while (exp_cli_q.size() > 0 && obs_cli_q.size() > 0)
            chk({tag, "_pk_data"}, obs_cli_q.pop_front(), exp_cli_q.pop_front());
        chk({tag, "_pk_left"}, 32'(obs_cli_q.size() + exp_cli_q.size()), 32'd0);
        while (exp_srv_q.size() > 0 && obs_srv_q.size() > 0)
            chk({tag, "_ct_data"}, obs_srv_q.pop_front(), exp_srv_q.pop_front());
        chk({tag, "_ct_left"}, 32'(obs_srv_q.size() + exp_srv_q.size()), 32'd0);
        obs_cli_q.delete(); exp_cli_q.delete();
        obs_srv_q.delete(); exp_srv_q.delete();
    endtask

    task automatic pulse_start(input int kk);
        start = 1'b1;
        k     = 3'(kk);
        step();
        start = 1'b0;
    endtask

    // Full exchange; noise adds off-phase words and a stray start while busy.
    task automatic run_xchg(input string tag, input int kk, input int gap_max, input bit noise);
        int base_cli, base_srv, base_done, base_ss;
        logic [31:0] d;
        base_cli  = cli_wen_n;
        base_srv  = srv_wen_n;
        base_done = done_n;
        base_ss   = sstart_n;
        pulse_start(kk);
        chk({tag, "_srv_start"}, 32'(srv_start), 32'd1);
        chk({tag, "_cli_start"}, 32'(cli_start), 32'd1);
        chk({tag, "_err_clr"}, 32'(err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        step();
        for (int i = 0; i < pk_len(kk); i++) begin
            d = $urandom;
            srv_valid = 1'b1; srv_dout = d;
            exp_cli_q.push_back(d);
            if (noise) begin
                cli_valid = 1'b1; cli_dout = 32'hDEADBEEF;
                if (i == 20) begin start = 1'b1; k = 3'd2; end
            end
            step();
            srv_valid = 1'b0; cli_valid = 1'b0; start = 1'b0;
            repeat ($urandom_range(0, gap_max)) step();
            if (i == 99) chk({tag, "_pk_wcnt"}, 32'(word_cnt), 32'd100);
        end
        chk({tag, "_pk_wcnt_clr"}, 32'(word_cnt), 32'd0);
        for (int i = 0; i < ct_len(kk); i++) begin
            d = $urandom;
            cli_valid = 1'b1; cli_dout = d;
            exp_srv_q.push_back(d);
            if (noise) begin srv_valid = 1'b1; srv_dout = 32'hDEADBEEF; end
            step();
            srv_valid = 1'b0; cli_valid = 1'b0;
            if (i < ct_len(kk) - 1) repeat ($urandom_range(0, gap_max)) step();
            if (i == 99) chk({tag, "_ct_wcnt"}, 32'(word_cnt), 32'd100);
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        step(); step();
        drain(tag);
        chk({tag, "_cli_wen_n"}, 32'(cli_wen_n - base_cli), 32'(pk_len(kk)));
        chk({tag, "_srv_wen_n"}, 32'(srv_wen_n - base_srv), 32'(ct_len(kk)));
        chk({tag, "_done_n"}, 32'(done_n - base_done), 32'd1);
        chk({tag, "_start_n"}, 32'(sstart_n - base_ss), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int base_ss, base_cs, base_done;
        logic [31:0] d;
        int bad_k[5] = '{0, 1, 5, 6, 7};

        rst = 1'b1; start = 1'b0; k = 3'd0;
        srv_valid = 1'b0; cli_valid = 1'b0; srv_dout = '0; cli_dout = '0;
        step(); step();
        chk("rst_ctl", 32'({busy, done, err, srv_start, cli_start, srv_wen, cli_wen, word_cnt}), 32'd0);
        chk("rst_din", cli_din | srv_din, 32'd0);
        rst = 1'b0;
        step();

        run_xchg("k2", 2, 0, 1'b0);
        run_xchg("k4gap", 4, 3, 1'b0);

        foreach (bad_k[j]) begin
            base_ss = sstart_n; base_cs = cstart_n;
            pulse_start(bad_k[j]);
            chk("badk_busy", 32'(busy), 32'd1);
            chk("badk_nostart", 32'(srv_start | cli_start), 32'd0);
            step();
            chk("badk_err", 32'(err), 32'd1);
            chk("badk_idle", 32'(busy), 32'd0);
            chk("badk_pulses", 32'((sstart_n - base_ss) + (cstart_n - base_cs)), 32'd0);
        end

        run_xchg("k3noise", 3, 1, 1'b1);

        // Server stalls after 100 words.
        pulse_start(3);
        step();
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            srv_valid = 1'b1; srv_dout = d;
            exp_cli_q.push_back(d);
            step();
        end
        srv_valid = 1'b0;
        repeat (TO) step();
        chk("tmo_not_yet", 32'(err), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd1);
        step();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            srv_valid = 1'b1; srv_dout = $urandom;
            step();
        end
        srv_valid = 1'b0;
        step(); step();
        drain("tmo");

        // Reset in the middle of the pk phase.
        base_done = done_n;
        pulse_start(2);
        step();
        for (int i = 0; i < 50; i++) begin
            d = $urandom;
            srv_valid = 1'b1; srv_dout = d;
            exp_cli_q.push_back(d);
            step();
        end
        srv_valid = 1'b0;
        chk("mid_wcnt", 32'(word_cnt), 32'd50);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_ctl", 32'({busy, done, err, srv_start, cli_start, srv_wen, cli_wen, word_cnt}), 32'd0);
        chk("mid_rst_din", cli_din | srv_din, 32'd0);
        rst = 1'b0;
        step();
        drain("mid");
        chk("mid_no_done", 32'(done_n - base_done), 32'd0);
        chk("mid_no_err", 32'(err), 32'd0);
        run_xchg("k2post", 2, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/kyber_xchg_ctrl.md
KYBER_XCHG_CTRL -- requirements
Module: kyber_xchg_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 4096, sets the maximum idle cycles allowed while a transfer is waiting for or inside a word stream.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to run one key exchange; ignored while busy.
REQ-005 k  input  3  Kyber module rank; only 2, 3, 4 are legal; sampled on accepted start.
REQ-006 busy  output  1  high from the cycle after an accepted start until DONE/ERR is left.
REQ-007 done  output  1  one-cycle pulse on successful completion.
REQ-008 err  output  1  sticky error flag, cleared on the next accepted start.
REQ-009 srv_start, cli_start  output  1 each  one-cycle start pulses to the server and client cores.
REQ-010 srv_valid / srv_dout  input  1 / 32  server output word stream (pk).
REQ-011 cli_valid / cli_dout  input  1 / 32  client output word stream (ciphertext).
REQ-012 cli_wen / cli_din  output  1 / 32  forwarded pk words into the client.
REQ-013 srv_wen / srv_din  output  1 / 32  forwarded ciphertext words into the server.
REQ-014 word_cnt  output  10  words forwarded in the current phase.

Function
REQ-015 States: IDLE, START, PK_XFER, CT_XFER, DONE, ERR; state encoding is internal.
REQ-016 IDLE + start with legal k: latch k, clear err and word_cnt, go to START.
REQ-017 IDLE + start with illegal k (0, 1, 5-7): go to ERR; no start pulses are issued.
REQ-018 START lasts one cycle: srv_start and cli_start pulse together, then go to PK_XFER.
REQ-019 Expected pk length: 96k+8 words (200/296/392). Expected ciphertext length: 192/272/392 words for k=2/3/4.
REQ-020 PK_XFER: each srv_valid cycle registers srv_dout to cli_din and asserts cli_wen on the next cycle (1-cycle latency) and increments word_cnt.
REQ-021 On the last pk word: word_cnt clears and the state goes to CT_XFER in the same edge.
REQ-022 CT_XFER: cli_valid words are forwarded to srv_din/srv_wen with 1-cycle latency; after the last word, go to DONE.
REQ-023 Valid words from the non-active source, or arriving in IDLE/START/DONE/ERR, are dropped and never forwarded.
REQ-024 Simultaneous srv_valid and cli_valid: only the active-phase source is forwarded.
REQ-025 Timeout counter: clears on every forwarded word and on each phase entry; when it reaches TIMEOUT-1 with no valid, go to ERR.
REQ-026 DONE lasts one cycle: done pulses high, then return to IDLE.
REQ-027 ERR lasts one cycle: err sets and holds, then return to IDLE.
REQ-028 start while busy is ignored and has no effect on state or counters.
REQ-029 Outputs are registered; no combinational input-to-output path.

Reset
REQ-030 rst forces IDLE and clears busy, done, err, srv_start, cli_start, srv_wen, cli_wen, srv_din, cli_din, word_cnt, the timeout counter and the latched k.
REQ-031 rst asserted mid-transfer aborts the exchange immediately; no done or err is produced and the next start proceeds normally.

Structure
REQ-032 Legal-k values, the pk/ct word-count tables and the state typedef SHALL live in a shared package kyber_pkg, reused by the server and client cores.
REQ-033 One sub-module, kyber_word_fwd, SHALL implement a single 1-cycle register stage (valid + 32-bit data); it is instantiated twice, once per direction.

Verification
REQ-034 k=2, start, server sends 200 words back-to-back, then client sends 192 words -> cli_wen high 200 cycles; srv_wen high 192 cycles; done pulses once; err=0.
REQ-035 k=4 with random valid gaps shorter than TIMEOUT -> exactly 392 words forwarded each direction, data order preserved, done=1.
REQ-036 k=5, start -> no srv_start/cli_start pulse; err=1 two cycles after start; busy returns low.
REQ-037 k=3, server stalls after 100 words for TIMEOUT cycles -> ERR; err=1; words after the stall are not forwarded.
REQ-038 cli_valid asserted during PK_XFER with 0xDEADBEEF, plus a second start mid-run -> cli data not on srv_din; word counts unchanged; start ignored.
REQ-039 rst pulsed at word 50 of PK_XFER -> all outputs 0 next cycle; a new k=2 exchange completes with done=1.
